// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
//
// Contents:
//   state_t        controller state encoding (IDLE / RUN / DONE)
//   booth_digit_t  radix-4 Booth digit, signed, range -2..+2
//   booth_decode   maps a multiplier bit triplet {b[2i+1], b[2i], b[2i-1]} to its digit
//   rw_f / n_f     row width and digit count for a given operand width
//
// Optional feature macro: MULT_BOOTH_UNSIGNED_EN (adds one digit so that
// unsigned operands are also supported; N then becomes WIDTH/2+1).
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic signed [2:0] booth_digit_t;

    // Defaults for the 16-bit datapath.
    localparam int MULT_WIDTH = 16;
    localparam int RW         = 2 * MULT_WIDTH - 1;
`ifdef MULT_BOOTH_UNSIGNED_EN
    localparam int N          = MULT_WIDTH / 2 + 1;
`else
    localparam int N          = MULT_WIDTH / 2;
`endif

    // Width of each redundant output row (product bits [2W-1:1]).
    function automatic int rw_f(input int width);
        return 2 * width - 1;
    endfunction

    // Number of Booth digits retired per operation.
    function automatic int n_f(input int width);
`ifdef MULT_BOOTH_UNSIGNED_EN
        return width / 2 + 1;
`else
        return width / 2;
`endif
    endfunction

    // Standard radix-4 Booth recoding of one overlapping triplet.
    function automatic booth_digit_t booth_decode(input logic [2:0] trip);
        booth_digit_t d;
        case (trip)
            3'b000:  d = 3'sb000;
            3'b001:  d = 3'sb001;
            3'b010:  d = 3'sb001;
            3'b011:  d = 3'sb010;
            3'b100:  d = 3'sb110;
            3'b101:  d = 3'sb111;
            3'b110:  d = 3'sb111;
            3'b111:  d = 3'sb000;
            default: d = 3'sb000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator.
//
// Ports:
//   a_ext  in  2W   multiplicand already extended to 2W bits (sign or zero)
//   trip   in  3    multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//   shift  in  SHW  left shift amount (2*i)
//   pp     out 2W   (digit * a_ext) << shift, modulo 2^(2W)
//
// Negative digits are formed with an exact two's complement negation, so the
// accumulator needs no separate correction bit.
module booth_pp_gen
    import mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic [2*WIDTH-1:0] a_ext,
    input  logic [2:0]         trip,
    input  logic [SHW-1:0]     shift,
    output logic [2*WIDTH-1:0] pp
);

    localparam int PW = 2 * WIDTH;

    booth_digit_t    digit_s;
    logic            neg_s;
    logic            two_s;
    logic [PW-1:0]   mag_s;
    logic [PW-1:0]   sgn_s;

    // Decode the digit into magnitude select, sign, and shifted partial product.
    always_comb begin
        digit_s = booth_decode(trip);
        neg_s   = digit_s[2];
        two_s   = (digit_s == 3'sb010) || (digit_s == 3'sb110);
        mag_s   = '0;
        if (digit_s == 3'sb000) begin
            mag_s = '0;
        end else if (two_s) begin
            mag_s = a_ext << 1;
        end else begin
            mag_s = a_ext;
        end
        if (neg_s) begin
            sgn_s = ~mag_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            sgn_s = mag_s;
        end
        pp = sgn_s << shift;
    end

endmodule

// File: rtl/mult16s_booth_csa_seq.sv
// Sequential radix-4 Booth multiplier front end: retires one Booth digit per
// clock into carry-save sum/carry registers and hands the two redundant rows
// to the downstream carry-propagate adder with a valid/ready handshake.
//
// Product reconstruction: P[0] = prod_lsb, P[2W-1:1] = (row_a + row_b) mod 2^(2W-1).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      operands accepted this cycle (combinational from out_ready)
//   tc         in   1      1 = signed, 0 = unsigned (only with MULT_BOOTH_UNSIGNED_EN)
//   a          in   W      multiplicand
//   b          in   W      multiplier
//   out_valid  out  1      rows valid
//   out_ready  in   1      downstream accepts rows
//   row_a      out  2W-1   sum row (product bits [2W-1:1])
//   row_b      out  2W-1   carry row (product bits [2W-1:1])
//   prod_lsb   out  1      product bit 0
//
// Optional feature macro: MULT_BOOTH_UNSIGNED_EN. When defined, the tc port
// exists and every operation takes WIDTH/2+1 digits regardless of tc.
// WIDTH must be even and at least 4.
module mult16s_booth_csa_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
`ifdef MULT_BOOTH_UNSIGNED_EN
    input  logic               tc,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-2:0] row_a,
    output logic [2*WIDTH-2:0] row_b,
    output logic               prod_lsb
);

    localparam int PW    = 2 * WIDTH;
    localparam int ROW_W = rw_f(WIDTH);
    localparam int N_DIG = n_f(WIDTH);
    localparam int CW    = $clog2(N_DIG);
    localparam int SHW   = CW + 1;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               tc_s;
    logic [PW-1:0]      s_r;
    logic [PW-1:0]      c_r;
    logic               out_valid_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               run_s;
    logic               last_s;
    logic [PW-1:0]      a_ext_s;
    logic [WIDTH+2:0]   b_ext_s;
    logic [2:0]         trip_s;
    logic [SHW-1:0]     shift_s;
    logic [PW-1:0]      pp_s;
    logic [PW-1:0]      s_nxt_s;
    logic [PW-1:0]      c_nxt_s;

`ifdef MULT_BOOTH_UNSIGNED_EN
    logic               tc_r;

    // Operand mode captured alongside the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_r <= 1'b1;
        end else if (accept_s) begin
            tc_r <= tc;
        end else begin
            tc_r <= tc_r;
        end
    end

    assign tc_s = tc_r;
`else
    assign tc_s = 1'b1;
`endif

    assign last_s = (cnt_r == CW'(N_DIG - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DONE with out_ready and in_valid chains straight into RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready && in_valid) begin
                    state_nxt_s = ST_RUN;
                end else if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake and datapath enables decoded from the current state.
    always_comb begin
        in_ready_s = 1'b0;
        run_s      = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_RUN:  run_s      = 1'b1;
            ST_DONE: in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
        accept_s = in_ready_s && in_valid;
    end

    assign in_ready = in_ready_s;

    // Multiplicand extension and multiplier triplet for the current digit.
    // b is padded with b[-1]=0 below and two extension bits above; with tc=0
    // the extra unsigned digit therefore decodes {0, 0, b[W-1]}.
    assign a_ext_s = {{WIDTH{tc_s & a_r[WIDTH-1]}}, a_r};
    assign b_ext_s = {{2{tc_s & b_r[WIDTH-1]}}, b_r, 1'b0};
    assign shift_s = {cnt_r, 1'b0};
    assign trip_s  = 3'(b_ext_s >> shift_s);

    booth_pp_gen #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_pp_gen (
        .a_ext (a_ext_s),
        .trip  (trip_s),
        .shift (shift_s),
        .pp    (pp_s)
    );

    // 3:2 carry-save compression of the running rows with the new partial product.
    always_comb begin
        s_nxt_s = s_r ^ c_r ^ pp_s;
        c_nxt_s = ((s_r & c_r) | (s_r & pp_s) | (c_r & pp_s)) << 1;
    end

    // Operand capture, digit counter and carry-save accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            cnt_r <= '0;
            s_r   <= '0;
            c_r   <= '0;
        end else if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            cnt_r <= '0;
            s_r   <= '0;
            c_r   <= '0;
        end else if (run_s) begin
            s_r <= s_nxt_s;
            c_r <= c_nxt_s;
            if (!last_s) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            cnt_r <= cnt_r;
            s_r   <= s_r;
            c_r   <= c_r;
        end
    end

    // Registered result-valid flag, tracking entry into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign out_valid = out_valid_r;
    assign row_a     = s_r[PW-1:1];
    assign row_b     = c_r[PW-1:1];
    assign prod_lsb  = s_r[0];

    // ROW_W documents the row width derived from the package helper.
    if (ROW_W != PW - 1) begin : g_bad_width
        $error("row width mismatch");
    end

endmodule

// File: tb/tb_mult16s_booth_csa_seq.sv
// Self-checking bench for mult16s_booth_csa_seq (WIDTH=16): directed vector
// table, stall/back-to-back handshake, mid-run reset, and a random sweep.
module tb_mult16s_booth_csa_seq;

    localparam int W  = 16;
    localparam int RW = 2 * W - 1;
`ifdef MULT_BOOTH_UNSIGNED_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          tc;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] row_a;
    logic [RW-1:0] row_b;
    logic          prod_lsb;

    int n_checks = 0;
    int n_fail   = 0;

    mult16s_booth_csa_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MULT_BOOTH_UNSIGNED_EN
        .tc        (tc),
`endif
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_a     (row_a),
        .row_b     (row_b),
        .prod_lsb  (prod_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [31:0]  p;
        string        name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] product();
        logic [RW-1:0] hi;
        hi = row_a + row_b;
        return {hi, prod_lsb};
    endfunction

    // Called at a negedge right after the accept edge; waits for out_valid.
    task automatic wait_result(input string name, input logic [31:0] exp);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(LAT));
        check({name, "_prod"}, 64'(product()), 64'(exp));
    endtask

    // Drive one operand pair at a negedge, then wait for its result.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic tcv, input logic [31:0] exp, input string name);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        a = av; b = bv; tc = tcv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~av; b = ~bv;
        wait_result(name, exp);
    endtask

    initial begin
        logic [RW-1:0] ra_s;
        logic [RW-1:0] rb_s;
        logic          lsb_s;
        logic          seen;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [31:0]   rp;

        vecs[0]  = '{16'h0003, 16'h0005, 32'h0000000F, "v3x5"};
        vecs[1]  = '{16'h8000, 16'h8000, 32'h40000000, "vminxmin"};
        vecs[2]  = '{16'hFFFF, 16'h0001, 32'hFFFFFFFF, "vm1x1"};
        vecs[3]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, "vmaxxmax"};
        vecs[4]  = '{16'h8000, 16'h7FFF, 32'hC0008000, "vminxmax"};
        vecs[5]  = '{16'h0000, 16'h1234, 32'h00000000, "v0"};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 32'h00000001, "vm1xm1"};
        vecs[7]  = '{16'h0100, 16'h0100, 32'h00010000, "v256sq"};
        vecs[8]  = '{16'hFFFE, 16'h0003, 32'hFFFFFFFA, "vm2x3"};
        vecs[9]  = '{16'h1234, 16'h0002, 32'h00002468, "vx2"};
        vecs[10] = '{16'h8000, 16'h0001, 32'hFFFF8000, "vminx1"};
        vecs[11] = '{16'h7FFF, 16'hFFFF, 32'hFFFF8001, "vmaxxm1"};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tc = 1'b1;
        a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_rows", 64'({row_a, row_b, prod_lsb}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, 1'b1, vecs[i].p, vecs[i].name);
            @(negedge clk);
        end

`ifdef MULT_BOOTH_UNSIGNED_EN
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "uns_ffff");
        @(negedge clk);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "sgn_ffff");
        @(negedge clk);
        do_op(16'h8000, 16'h0003, 1'b0, 32'h00018000, "uns_8000x3");
        @(negedge clk);
`endif

        // Stall in DONE for 20 cycles, then release with a same-cycle accept.
        out_ready = 1'b0;
        do_op(16'h0007, 16'hFFFD, 1'b1, 32'hFFFFFFEB, "stall");
        ra_s = row_a; rb_s = row_b; lsb_s = prod_lsb;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_hold", 64'({out_valid, in_ready, row_a, row_b, prod_lsb}),
                  64'({1'b1, 1'b0, ra_s, rb_s, lsb_s}));
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h0003; b = 16'h0005; tc = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("b2b", 32'h0000000F);
        @(negedge clk);

        // Reset pulsed at cnt=3 abandons the operation.
        a = 16'h1234; b = 16'h5555; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_clear", 64'({out_valid, row_a, row_b, prod_lsb}), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_stale", 64'(seen), 64'd0);
        do_op(16'h0003, 16'h0005, 1'b1, 32'h0000000F, "post_rst");
        @(negedge clk);

        // Random signed pairs with random output back-pressure.
        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rp = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
            out_ready = 1'($urandom_range(0, 1));
            do_op(ra, rb, 1'b1, rp, "rand");
            if (!out_ready) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check("rand_hold_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
